pipe_controller: RTL and testbench

Pipelined control unit for the five-stage ARM core. It decodes the Decode-stage instruction word that the datapath exports and carries the resulting control bits through Execute, Memory and Writeback pipeline registers. It holds the architectural NZCV flags and evaluates condition codes in Execute. It also produces the branch-taken and PC-write-pending signals used by the datapath and the hazard unit.

---
 rtl/pipe_controller.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// Control unit for the five-stage ARM pipeline: decodes InstrD, carries control bits
// through Execute/Memory/Writeback, holds NZCV and evaluates condition codes in Execute.
module pipe_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemtoRegE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        BrLW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef struct packed {
        logic [3:0] cond;
        logic       alu_src;
        logic [2:0] alu_control;
        logic [1:0] flag_w;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       br_l;
        logic       pc_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic br_l;
        logic pc_src;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic br_l;
        logic pc_src;
    } wb_ctrl_t;

    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       u_bit;
    logic       link_bit;
    logic [3:0] rd;
    logic       unused_instr_bits;

    assign op                = InstrD[27:26];
    assign i_bit             = InstrD[25];
    assign cmd               = InstrD[24:21];
    assign s_bit             = InstrD[20];
    assign u_bit             = InstrD[23];
    assign link_bit          = InstrD[24];
    assign rd                = InstrD[15:12];
    assign unused_instr_bits = ^InstrD[11:0];

    logic       dp_hit;
    logic       dp_arith;
    logic [2:0] dp_alu;
    logic [1:0] reg_src_d;
    logic [1:0] imm_src_d;
    logic       alu_src_d;
    logic [2:0] alu_control_d;
    logic [1:0] flag_w_d;
    logic       reg_write_d;
    logic       mem_write_d;
    logic       mem_to_reg_d;
    logic       branch_d;
    logic       br_l_d;
    logic       pc_src_d;

    always_comb begin : decode
        dp_hit   = 1'b0;
        dp_arith = 1'b0;
        dp_alu   = ALU_ADD;
        case (cmd)
            CMD_ADD: begin dp_hit = 1'b1; dp_arith = 1'b1; dp_alu = ALU_ADD; end
            CMD_SUB: begin dp_hit = 1'b1; dp_arith = 1'b1; dp_alu = ALU_SUB; end
            CMD_CMP: begin dp_hit = 1'b1; dp_arith = 1'b1; dp_alu = ALU_SUB; end
            CMD_AND: begin dp_hit = 1'b1; dp_alu = ALU_AND; end
            CMD_ORR: begin dp_hit = 1'b1; dp_alu = ALU_ORR; end
            CMD_EOR: begin dp_hit = 1'b1; dp_alu = ALU_EOR; end
            CMD_MOV: begin dp_hit = 1'b1; dp_alu = ALU_MOV; end
            default: ;
        endcase

        reg_src_d     = 2'b00;
        imm_src_d     = 2'b00;
        alu_src_d     = 1'b0;
        alu_control_d = ALU_ADD;
        flag_w_d      = 2'b00;
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        branch_d      = 1'b0;
        br_l_d        = 1'b0;

        case (op)
            2'b00: begin
                // Unrecognised data-processing commands fall through as NOPs.
                if (dp_hit) begin
                    alu_src_d     = i_bit;
                    alu_control_d = dp_alu;
                    reg_write_d   = (cmd != CMD_CMP);
                    if (cmd == CMD_CMP)
                        flag_w_d = 2'b11;
                    else if (s_bit)
                        flag_w_d = dp_arith ? 2'b11 : 2'b10;
                end
            end
            2'b01: begin
                alu_src_d     = 1'b1;
                imm_src_d     = 2'b01;
                alu_control_d = u_bit ? ALU_ADD : ALU_SUB;
                if (s_bit) begin
                    reg_write_d  = 1'b1;
                    mem_to_reg_d = 1'b1;
                end else begin
                    mem_write_d  = 1'b1;
                    reg_src_d[1] = 1'b1;
                end
            end
            2'b10: begin
                branch_d      = 1'b1;
                alu_src_d     = 1'b1;
                imm_src_d     = 2'b10;
                alu_control_d = ALU_ADD;
                reg_src_d[0]  = 1'b1;
                if (link_bit) begin
                    reg_write_d = 1'b1;
                    br_l_d      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // BL writes R14, so only non-link writes to R15 redirect the PC.
    assign pc_src_d = reg_write_d & (rd == 4'hF) & ~br_l_d;

    ex_ctrl_t  ex_d,    ex_q;
    mem_ctrl_t mem_d,   mem_q;
    wb_ctrl_t  wb_d,    wb_q;
    logic [3:0] flags_d, flags_q;
    logic       cond_ex;

    always_comb begin : ex_next
        ex_d = '0;
        if (!FlushE) begin
            ex_d.cond        = InstrD[31:28];
            ex_d.alu_src     = alu_src_d;
            ex_d.alu_control = alu_control_d;
            ex_d.flag_w      = flag_w_d;
            ex_d.reg_write   = reg_write_d;
            ex_d.mem_write   = mem_write_d;
            ex_d.mem_to_reg  = mem_to_reg_d;
            ex_d.branch      = branch_d;
            ex_d.br_l        = br_l_d;
            ex_d.pc_src      = pc_src_d;
        end
    end

    always_comb begin : cond_check
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        case (ex_q.cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin : flags_next
        flags_d = flags_q;
        if (ex_q.flag_w[1] & cond_ex)
            flags_d[3:2] = ALUFlags[3:2];
        if (ex_q.flag_w[0] & cond_ex)
            flags_d[1:0] = ALUFlags[1:0];
    end

    always_comb begin : mem_next
        mem_d.reg_write  = ex_q.reg_write & cond_ex;
        mem_d.mem_write  = ex_q.mem_write & cond_ex;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        mem_d.br_l       = ex_q.br_l;
        mem_d.pc_src     = ex_q.pc_src & cond_ex;
    end

    always_comb begin : wb_next
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.mem_to_reg = mem_q.mem_to_reg;
        wb_d.br_l       = mem_q.br_l;
        wb_d.pc_src     = mem_q.pc_src;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            flags_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            flags_q <= flags_d;
        end
    end

    assign RegSrcD      = reg_src_d;
    assign ImmSrcD      = imm_src_d;
    assign ALUSrcE      = ex_q.alu_src;
    assign ALUControlE  = ex_q.alu_control;
    assign BranchTakenE = ex_q.branch & cond_ex;
    assign MemtoRegE    = ex_q.mem_to_reg;
    assign RegWriteM    = mem_q.reg_write;
    assign MemWriteM    = mem_q.mem_write;
    assign RegWriteW    = wb_q.reg_write;
    assign MemtoRegW    = wb_q.mem_to_reg;
    assign BrLW         = wb_q.br_l;
    assign PCSrcW       = wb_q.pc_src;
    assign PCWrPendingF = pc_src_d | ex_q.pc_src | mem_q.pc_src;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: decode fields, E/M/W control timing, flags,
// condition codes, flush and asynchronous reset behaviour.
module tb_pipe_controller;

    localparam logic [31:0] I_NOP    = 32'hEC000000;
    localparam logic [31:0] I_SUBS   = 32'hE2500000;
    localparam logic [31:0] I_BEQ    = 32'h0A000002;
    localparam logic [31:0] I_BNE    = 32'h1A000000;
    localparam logic [31:0] I_ADDSNE = 32'h12911001;
    localparam logic [31:0] I_LDR    = 32'hE5910004;
    localparam logic [31:0] I_STR    = 32'hE5810004;
    localparam logic [31:0] I_MOVPC  = 32'hE1A0F001;
    localparam logic [31:0] I_BL     = 32'hEB000004;

    logic        clk;
    logic        reset;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlags;
    logic        FlushE;
    logic [1:0]  RegSrcD;
    logic [1:0]  ImmSrcD;
    logic        ALUSrcE;
    logic [2:0]  ALUControlE;
    logic        BranchTakenE;
    logic        MemtoRegE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic        BrLW;
    logic        PCSrcW;
    logic        PCWrPendingF;

    int checks;
    int failures;
    logic [0:0] exp_q[$];

    logic [11:0] reg_outs;
    assign reg_outs = {ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, RegWriteM,
                       MemWriteM, RegWriteW, MemtoRegW, BrLW, PCSrcW};

    pipe_controller dut (
        .clk          (clk),
        .reset        (reset),
        .InstrD       (InstrD),
        .ALUFlags     (ALUFlags),
        .FlushE       (FlushE),
        .RegSrcD      (RegSrcD),
        .ImmSrcD      (ImmSrcD),
        .ALUSrcE      (ALUSrcE),
        .ALUControlE  (ALUControlE),
        .BranchTakenE (BranchTakenE),
        .MemtoRegE    (MemtoRegE),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .BrLW         (BrLW),
        .PCSrcW       (PCSrcW),
        .PCWrPendingF (PCWrPendingF)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [31:0] instr, input logic [3:0] flags, input logic flush);
        InstrD   = instr;
        ALUFlags = flags;
        FlushE   = flush;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       taken;
    } cond_vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  src_ctrl;
    } alu_vec_t;

    cond_vec_t cond_tab[16];
    alu_vec_t  alu_tab[6];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        InstrD   = I_NOP;
        ALUFlags = 4'b0000;
        FlushE   = 1'b0;

        cond_tab[0]  = '{4'b1000, 4'hB, 1'b1};
        cond_tab[1]  = '{4'b1000, 4'hA, 1'b0};
        cond_tab[2]  = '{4'b1000, 4'hF, 1'b0};
        cond_tab[3]  = '{4'b0010, 4'h8, 1'b1};
        cond_tab[4]  = '{4'b0110, 4'h8, 1'b0};
        cond_tab[5]  = '{4'b0110, 4'h9, 1'b1};
        cond_tab[6]  = '{4'b1001, 4'hC, 1'b1};
        cond_tab[7]  = '{4'b0001, 4'hD, 1'b1};
        cond_tab[8]  = '{4'b0001, 4'h6, 1'b1};
        cond_tab[9]  = '{4'b0000, 4'h2, 1'b0};
        cond_tab[10] = '{4'b0100, 4'h1, 1'b0};
        cond_tab[11] = '{4'b0000, 4'h5, 1'b1};
        cond_tab[12] = '{4'b1000, 4'h4, 1'b1};
        cond_tab[13] = '{4'b0010, 4'h3, 1'b0};
        cond_tab[14] = '{4'b0000, 4'h7, 1'b1};
        cond_tab[15] = '{4'b0100, 4'hD, 1'b1};

        alu_tab[0] = '{32'hE1800000, 4'b0011};
        alu_tab[1] = '{32'hE0200000, 4'b0100};
        alu_tab[2] = '{32'hE3A00001, 4'b1101};
        alu_tab[3] = '{32'hE5010004, 4'b1001};
        alu_tab[4] = '{32'hE0000000, 4'b0010};
        alu_tab[5] = '{32'hE1500000, 4'b0001};

        // Reset state
        #12;
        chk("reset_regs", 32'(reg_outs), 32'd0);
        chk("reset_pending", 32'(PCWrPendingF), 32'd0);
        chk("nop_dstage", 32'({RegSrcD, ImmSrcD}), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_regs", 32'(reg_outs), 32'd0);

        // SUBS sets Z, BEQ taken next cycle
        drive(I_SUBS, 4'b0000, 1'b0);
        chk("subs_dstage", 32'({RegSrcD, ImmSrcD}), 32'd0);
        tick();
        chk("subs_alu_e", 32'({ALUSrcE, ALUControlE}), 32'b1001);
        drive(I_BEQ, 4'b0100, 1'b0);
        chk("beq_dstage", 32'({RegSrcD, ImmSrcD}), 32'b0110);
        tick();
        chk("beq_taken_z1", 32'(BranchTakenE), 32'd1);
        drive(I_NOP, 4'b0000, 1'b0);
        tick();
        chk("nop_not_taken", 32'(BranchTakenE), 32'd0);

        // Same again with Z cleared
        drive(I_SUBS, 4'b0000, 1'b0);
        tick();
        drive(I_BEQ, 4'b0000, 1'b0);
        tick();
        chk("beq_not_taken_z0", 32'(BranchTakenE), 32'd0);
        drive(I_NOP, 4'b0000, 1'b0);
        tick();

        // ADDSNE with Z=1 must neither write a register nor touch flags
        drive(I_SUBS, 4'b0000, 1'b0);
        tick();
        drive(I_ADDSNE, 4'b0100, 1'b0);
        tick();
        chk("subs_regwrite_m", 32'(RegWriteM), 32'd1);
        drive(I_BEQ, 4'b0000, 1'b0);
        tick();
        chk("addne_suppressed_m", 32'(RegWriteM), 32'd0);
        chk("flags_kept_beq", 32'(BranchTakenE), 32'd1);
        drive(I_NOP, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) tick();

        // Flushed LDR; SUBS in E still writes flags (Z cleared) during the flush
        drive(I_SUBS, 4'b0000, 1'b0);
        tick();
        drive(I_LDR, 4'b0000, 1'b1);
        chk("ldr_dstage", 32'({RegSrcD, ImmSrcD}), 32'b0001);
        tick();
        chk("flush_memtoreg_e", 32'(MemtoRegE), 32'd0);
        drive(I_BEQ, 4'b0000, 1'b0);
        tick();
        chk("flush_regwrite_m", 32'(RegWriteM), 32'd0);
        chk("flush_keeps_flagw", 32'(BranchTakenE), 32'd0);
        chk("subs_regwrite_w", 32'(RegWriteW), 32'd1);
        drive(I_NOP, 4'b0000, 1'b0);
        tick();
        chk("flush_wb", 32'({RegWriteW, MemtoRegW}), 32'd0);

        // Unflushed LDR through E, M, W
        drive(I_LDR, 4'b0000, 1'b0);
        tick();
        chk("ldr_memtoreg_e", 32'(MemtoRegE), 32'd1);
        drive(I_NOP, 4'b0000, 1'b0);
        tick();
        chk("ldr_regwrite_m", 32'(RegWriteM), 32'd1);
        tick();
        chk("ldr_wb", 32'({RegWriteW, MemtoRegW}), 32'b11);

        // Condition codes: SUBS loads flags, then a branch with the given cond
        foreach (cond_tab[i]) begin
            drive(I_SUBS, 4'b0000, 1'b0);
            tick();
            drive({cond_tab[i].cond, 28'hA000000}, cond_tab[i].flags, 1'b0);
            tick();
            chk($sformatf("cond_%0h_flags_%b", cond_tab[i].cond, cond_tab[i].flags),
                32'(BranchTakenE), 32'(cond_tab[i].taken));
        end

        // ALU control and operand source per opcode
        foreach (alu_tab[i]) begin
            drive(alu_tab[i].instr, 4'b0000, 1'b0);
            tick();
            chk($sformatf("alu_%08h", alu_tab[i].instr),
                32'({ALUSrcE, ALUControlE}), 32'(alu_tab[i].src_ctrl));
        end
        drive(I_NOP, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) tick();

        // MOV PC,R1: pending for D, E, M; PCSrcW on the third edge
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        drive(I_MOVPC, 4'b0000, 1'b0);
        chk("movpc_pending_d", 32'(PCWrPendingF), 32'(exp_q.pop_front()));
        tick();
        drive(I_NOP, 4'b0000, 1'b0);
        chk("movpc_pending_e", 32'(PCWrPendingF), 32'(exp_q.pop_front()));
        tick();
        chk("movpc_pending_m", 32'(PCWrPendingF), 32'(exp_q.pop_front()));
        tick();
        chk("movpc_pending_w", 32'(PCWrPendingF), 32'(exp_q.pop_front()));
        chk("movpc_wb", 32'({PCSrcW, RegWriteW}), 32'b11);

        // BL
        drive(I_BL, 4'b0000, 1'b0);
        chk("bl_dstage", 32'({RegSrcD, ImmSrcD}), 32'b0110);
        chk("bl_no_pending", 32'(PCWrPendingF), 32'd0);
        tick();
        chk("bl_taken", 32'(BranchTakenE), 32'd1);
        drive(I_NOP, 4'b0000, 1'b0);
        tick();
        tick();
        chk("bl_wb", 32'({BrLW, RegWriteW, PCSrcW}), 32'b110);

        // Fill W=LDR, M=STR, E=BEQ with Z=1, then reset mid-stream
        drive(I_SUBS, 4'b0000, 1'b0);
        tick();
        drive(I_LDR, 4'b0100, 1'b0);
        tick();
        drive(I_STR, 4'b0000, 1'b0);
        chk("str_dstage", 32'({RegSrcD, ImmSrcD}), 32'b1001);
        tick();
        drive(I_BEQ, 4'b0000, 1'b0);
        tick();
        chk("pre_reset_live", 32'({MemWriteM, RegWriteW, BranchTakenE}), 32'b111);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_regs", 32'(reg_outs), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        chk("after_release", 32'({BranchTakenE, MemWriteM, RegWriteW, RegWriteM,
                                  MemtoRegW, BrLW, PCSrcW}), 32'd0);
        drive(I_BNE, 4'b0000, 1'b0);
        tick();
        chk("bne_after_reset", 32'(BranchTakenE), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
